// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch/decode/regread/execute/memory/writeback,
// with memory-ready handshake, sticky timeout fault and halt/resume.
module control_unit #(
  parameter logic [3:0]  OP_LOAD     = 4'h8,
  parameter logic [3:0]  OP_STORE    = 4'h9,
  parameter logic [3:0]  OP_JMP      = 4'hC,
  parameter logic [3:0]  OP_NOP      = 4'h0,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned WAIT_W      = 4
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic [3:0]  I_opcode,
  input  logic        I_mem_ready,
  input  logic        I_branch_taken,
  input  logic        I_halt_req,
  input  logic        I_resume,
  output logic        O_fetch_en,
  output logic        O_decoder_en,
  output logic        O_regfile_en,
  output logic        O_alu_en,
  output logic        O_mem_en,
  output logic        O_mem_we,
  output logic        O_regfile_we,
  output logic [1:0]  O_pc_op,
  output logic [2:0]  O_state,
  output logic        O_fault,
  output logic [15:0] O_retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_REGREAD   = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic                taken_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [15:0]         retired_q;
  logic                mem_phase;
  logic                timeout;
  logic                is_mem_op;

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign timeout   = (wait_q == WAIT_W'(MEM_TIMEOUT));
  assign is_mem_op = (op_q == OP_LOAD) || (op_q == OP_STORE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (I_mem_ready) state_d = S_DECODE;
                   else if (timeout) state_d = S_FAULT;
      S_DECODE:    state_d = S_REGREAD;
      S_REGREAD:   state_d = S_EXECUTE;
      S_EXECUTE:   state_d = is_mem_op ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (I_mem_ready) state_d = S_WRITEBACK;
                   else if (timeout) state_d = S_FAULT;
      S_WRITEBACK: state_d = I_halt_req ? S_HALT : S_FETCH;
      S_HALT:      if (I_resume) state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Every output is a decode of registered state only, so a reset drops them at once.
  always_comb begin
    O_fetch_en   = 1'b0;
    O_decoder_en = 1'b0;
    O_regfile_en = 1'b0;
    O_alu_en     = 1'b0;
    O_mem_en     = 1'b0;
    O_mem_we     = 1'b0;
    O_regfile_we = 1'b0;
    O_pc_op      = 2'd0;
    O_fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        O_fetch_en = 1'b1;
        O_mem_en   = 1'b1;
      end
      S_DECODE:  O_decoder_en = 1'b1;
      S_REGREAD: O_regfile_en = 1'b1;
      S_EXECUTE: O_alu_en     = 1'b1;
      S_MEMORY: begin
        O_mem_en = 1'b1;
        O_mem_we = (op_q == OP_STORE);
      end
      S_WRITEBACK: begin
        O_regfile_we = !((op_q == OP_STORE) || (op_q == OP_JMP) || (op_q == OP_NOP));
        O_pc_op      = taken_q ? 2'd2 : 2'd1;
      end
      S_FAULT: O_fault = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      taken_q   <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_phase && !I_mem_ready)
        wait_q <= wait_q + 1'b1;
      if (state_q == S_REGREAD)
        op_q <= I_opcode;
      if (state_q == S_EXECUTE)
        taken_q <= (op_q == OP_JMP) && I_branch_taken;
      if (state_q == S_WRITEBACK)
        retired_q <= retired_q + 16'd1;
    end
  end

  assign O_state   = state_q;
  assign O_retired = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: cycle model plus directed instruction sequences.
module tb_control_unit;

  logic        I_clk;
  logic        I_reset;
  logic [3:0]  I_opcode;
  logic        I_mem_ready;
  logic        I_branch_taken;
  logic        I_halt_req;
  logic        I_resume;
  logic        O_fetch_en, O_decoder_en, O_regfile_en, O_alu_en;
  logic        O_mem_en, O_mem_we, O_regfile_we, O_fault;
  logic [1:0]  O_pc_op;
  logic [2:0]  O_state;
  logic [15:0] O_retired;

  int total = 0;
  int bad   = 0;

  control_unit #(.MEM_TIMEOUT(15), .WAIT_W(4)) dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_opcode(I_opcode),
    .I_mem_ready(I_mem_ready), .I_branch_taken(I_branch_taken),
    .I_halt_req(I_halt_req), .I_resume(I_resume),
    .O_fetch_en(O_fetch_en), .O_decoder_en(O_decoder_en),
    .O_regfile_en(O_regfile_en), .O_alu_en(O_alu_en),
    .O_mem_en(O_mem_en), .O_mem_we(O_mem_we), .O_regfile_we(O_regfile_we),
    .O_pc_op(O_pc_op), .O_state(O_state), .O_fault(O_fault),
    .O_retired(O_retired)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: phase number (0..7 as published), wait count, latched op/taken, retired.
  int          ms = 0;
  int          mw = 0;
  logic [3:0]  mop = 4'h0;
  bit          mtk = 1'b0;
  logic [15:0] mret = 16'h0;
  bit          mvalid = 1'b0;

  function automatic int m_next();
    int n;
    n = ms;
    case (ms)
      0: if (I_mem_ready) n = 1; else if (mw == 15) n = 7;
      1: n = 2;
      2: n = 3;
      3: n = (mop == 4'h8 || mop == 4'h9) ? 4 : 5;
      4: if (I_mem_ready) n = 5; else if (mw == 15) n = 7;
      5: n = I_halt_req ? 6 : 0;
      6: if (I_resume) n = 0;
      default: n = ms;
    endcase
    return n;
  endfunction

  always @(posedge I_clk or negedge I_reset) begin
    if (!I_reset) begin
      ms <= 0; mw <= 0; mop <= 4'h0; mtk <= 1'b0; mret <= 16'h0; mvalid <= 1'b1;
    end else begin
      ms <= m_next();
      if (m_next() != ms) mw <= 0;
      else if ((ms == 0 || ms == 4) && !I_mem_ready) mw <= mw + 1;
      if (ms == 2) mop <= I_opcode;
      if (ms == 3) mtk <= (mop == 4'hC) && I_branch_taken;
      if (ms == 5) mret <= mret + 16'd1;
    end
  end

  always @(negedge I_clk) begin
    if (mvalid) begin
      chk("m_state",      O_state,      ms);
      chk("m_fetch_en",   O_fetch_en,   ms == 0);
      chk("m_decoder_en", O_decoder_en, ms == 1);
      chk("m_regfile_en", O_regfile_en, ms == 2);
      chk("m_alu_en",     O_alu_en,     ms == 3);
      chk("m_mem_en",     O_mem_en,     ms == 0 || ms == 4);
      chk("m_mem_we",     O_mem_we,     ms == 4 && mop == 4'h9);
      chk("m_regfile_we", O_regfile_we,
          ms == 5 && !(mop == 4'h9 || mop == 4'hC || mop == 4'h0));
      chk("m_pc_op",      O_pc_op,      ms == 5 ? (mtk ? 2 : 1) : 0);
      chk("m_fault",      O_fault,      ms == 7);
      chk("m_retired",    O_retired,    mret);
    end
  end

  // Walks expected states at successive falling edges, driving I_mem_ready per step.
  task automatic run_seq(input string nm, input int st[$], input bit rd[$],
                         output int we, output int pc, output int mwe);
    we = -1; pc = -1; mwe = 0;
    for (int i = 0; i < st.size(); i++) begin
      if (i > 0) @(negedge I_clk);
      chk($sformatf("%s_state%0d", nm, i), O_state, st[i]);
      if (O_state == 3'd5) begin we = O_regfile_we; pc = O_pc_op; end
      if (O_state == 3'd4 && O_mem_we) mwe++;
      I_mem_ready = rd[i];
    end
  endtask

  int we, pc, mwe;

  initial begin
    I_reset = 1'b0; I_opcode = 4'h0; I_mem_ready = 1'b0;
    I_branch_taken = 1'b0; I_halt_req = 1'b0; I_resume = 1'b0;
    repeat (2) @(negedge I_clk);
    chk("rst_state",    O_state,    0);
    chk("rst_fetch_en", O_fetch_en, 1);
    chk("rst_mem_en",   O_mem_en,   1);
    chk("rst_alu_en",   O_alu_en,   0);
    chk("rst_fault",    O_fault,    0);
    chk("rst_retired",  O_retired,  0);
    #2 I_reset = 1'b1;
    @(negedge I_clk);

    I_opcode = 4'h1;
    run_seq("alu", '{0,1,2,3,5,0}, '{1,1,1,1,1,0}, we, pc, mwe);
    chk("alu_we", we, 1);
    chk("alu_pc", pc, 1);
    chk("alu_retired", O_retired, 1);

    I_opcode = 4'h9;
    run_seq("store", '{0,1,2,3,4,4,4,4,5,0}, '{1,0,0,0,0,0,0,1,0,0}, we, pc, mwe);
    chk("store_we", we, 0);
    chk("store_pc", pc, 1);
    chk("store_mem_we_cycles", mwe, 4);
    chk("store_retired", O_retired, 2);

    I_opcode = 4'hC; I_branch_taken = 1'b1;
    run_seq("jmp_t", '{0,1,2,3,5,0}, '{1,0,0,0,0,0}, we, pc, mwe);
    chk("jmp_t_we", we, 0);
    chk("jmp_t_pc", pc, 2);
    I_branch_taken = 1'b0;
    run_seq("jmp_n", '{0,1,2,3,5,0}, '{1,0,0,0,0,0}, we, pc, mwe);
    chk("jmp_n_we", we, 0);
    chk("jmp_n_pc", pc, 1);

    I_opcode = 4'h8;
    run_seq("load", '{0,1,2,3,4,4,5,0}, '{1,0,0,0,0,1,0,0}, we, pc, mwe);
    chk("load_we", we, 1);
    chk("load_mem_we_cycles", mwe, 0);
    chk("load_retired", O_retired, 5);

    I_opcode = 4'h2; I_halt_req = 1'b1;
    run_seq("halt", '{0,1,2,3,5,6}, '{1,0,0,0,0,0}, we, pc, mwe);
    chk("halt_retired", O_retired, 6);
    for (int i = 0; i < 9; i++) begin
      @(negedge I_clk);
      chk("halt_state", O_state, 6);
      chk("halt_enables", {O_fetch_en, O_decoder_en, O_regfile_en, O_alu_en,
                           O_mem_en, O_mem_we, O_regfile_we}, 0);
    end
    I_resume = 1'b1;
    @(negedge I_clk);
    chk("resume_state", O_state, 0);
    chk("resume_retired", O_retired, 6);
    I_resume = 1'b0; I_halt_req = 1'b0; I_mem_ready = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge I_clk);
      chk("to_wait_state", O_state, 0);
    end
    @(negedge I_clk);
    chk("to_fault_state", O_state, 7);
    chk("to_fault_flag", O_fault, 1);
    I_mem_ready = 1'b1; I_resume = 1'b1;
    repeat (3) @(negedge I_clk);
    chk("fault_sticky_state", O_state, 7);
    chk("fault_sticky_flag", O_fault, 1);
    I_mem_ready = 1'b0; I_resume = 1'b0;
    #2 I_reset = 1'b0;
    #1;
    chk("fault_rst_state", O_state, 0);
    chk("fault_rst_flag", O_fault, 0);
    chk("fault_rst_fetch", O_fetch_en, 1);
    @(negedge I_clk);
    #2 I_reset = 1'b1;
    @(negedge I_clk);

    I_opcode = 4'h9;
    run_seq("st_rst", '{0,1,2,3,4}, '{1,0,0,0,0}, we, pc, mwe);
    #2;
    chk("mid_mem_we", O_mem_we, 1);
    I_reset = 1'b0;
    #1;
    chk("arst_state", O_state, 0);
    chk("arst_mem_we", O_mem_we, 0);
    chk("arst_mem_en", O_mem_en, 1);
    chk("arst_regfile_we", O_regfile_we, 0);
    chk("arst_pc_op", O_pc_op, 0);
    chk("arst_retired", O_retired, 0);
    @(negedge I_clk);
    #2 I_reset = 1'b1;
    @(negedge I_clk);

    #1 force dut.retired_q = 16'hFFFF;
    mret = 16'hFFFF;
    #1 release dut.retired_q;
    chk("preload_retired", O_retired, 65535);
    I_opcode = 4'h1;
    run_seq("wrap", '{0,1,2,3,5,0}, '{1,0,0,0,0,0}, we, pc, mwe);
    chk("wrap_retired", O_retired, 0);
    chk("wrap_we", we, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle sequencer for the CPU core. Steps each instruction through fetch, decode, register read, execute, optional memory access and writeback. Drives the enable strobes of the decoder, register file, ALU and memory port, plus the PC update command. Handles the memory ready handshake, a timeout fault, and halt/resume.

Parameters:
OP_LOAD, 4'h8, opcode requiring a memory read
OP_STORE, 4'h9, opcode requiring a memory write
OP_JMP, 4'hC, jump opcode (no register write)
OP_NOP, 4'h0, no-op (no register write)
MEM_TIMEOUT, 15, wait cycles without I_mem_ready before FAULT
WAIT_W, 4, width of wait counter (must hold MEM_TIMEOUT)

Ports:
I_clk  in  1  clock, rising edge
I_reset  in  1  asynchronous, active-low reset
I_opcode  in  4  opcode from decoder, valid from REGREAD onward
I_mem_ready  in  1  memory handshake: access complete this cycle
I_branch_taken  in  1  jump condition, sampled in EXECUTE
I_halt_req  in  1  halt request, sampled in WRITEBACK
I_resume  in  1  leave HALT
O_fetch_en  out  1  instruction register load enable (FETCH)
O_decoder_en  out  1  decoder enable
O_regfile_en  out  1  register file read enable
O_alu_en  out  1  ALU enable
O_mem_en  out  1  memory request
O_mem_we  out  1  memory write (with O_mem_en)
O_regfile_we  out  1  register file write enable
O_pc_op  out  2  0 hold, 1 increment, 2 load jump target
O_state  out  3  current state encoding
O_fault  out  1  sticky memory-timeout fault
O_retired  out  16  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, REGREAD=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Reset (I_reset=0, asynchronous):
  - state=FETCH; op register=0; taken flag=0; wait counter=0; O_fault=0; O_retired=0.
  - All outputs are pure decodes of registered state; during reset only O_fetch_en=1 and O_mem_en=1.
- FETCH:
  - O_fetch_en=1, O_mem_en=1, O_mem_we=0.
  - Go to DECODE on I_mem_ready; otherwise stay and increment the wait counter.
- DECODE: O_decoder_en=1 for exactly one cycle; go to REGREAD.
- REGREAD:
  - O_regfile_en=1.
  - I_opcode is latched into the op register on the exit edge; go to EXECUTE.
- EXECUTE:
  - O_alu_en=1.
  - If op=OP_JMP, latch taken flag = I_branch_taken; otherwise taken flag=0.
  - If op is OP_LOAD or OP_STORE, go to MEMORY; otherwise go to WRITEBACK.
- MEMORY:
  - O_mem_en=1; O_mem_we=1 only when op=OP_STORE.
  - Go to WRITEBACK on I_mem_ready; otherwise stay and count.
- WRITEBACK:
  - O_regfile_we=1 unless op is OP_STORE, OP_JMP or OP_NOP.
  - O_pc_op=2 if taken flag is set, else 1. O_pc_op=0 in every other state.
  - O_retired increments by 1, wrapping 16'hFFFF to 0.
  - Next state is HALT if I_halt_req=1, else FETCH.
- HALT:
  - All enables 0.
  - Go to FETCH on I_resume; I_halt_req is ignored.
- Wait counter:
  - Cleared on every state change.
  - Increments only in FETCH/MEMORY while I_mem_ready=0.
  - If the counter equals MEM_TIMEOUT and I_mem_ready=0, go to FAULT. I_mem_ready=1 in that same cycle wins.
- FAULT:
  - All enables 0; O_fault=1.
  - Terminal: exit only via reset.
- Ready outside FETCH/MEMORY: I_mem_ready is ignored.
- Reset mid-operation: immediate return to FETCH. No partial writeback or PC update occurs because the outputs drop with the state.
- Instruction timing:
  - ALU op with zero-wait memory: 5 cycles (F, D, R, E, W).
  - Load/store: 6 cycles plus memory wait cycles.

Test Plan:
- ALU op (I_opcode=4'h1), I_mem_ready=1 in FETCH → O_state sequence 0,1,2,3,5,0; O_regfile_we=1 only in cycle 5; O_pc_op=1 in WRITEBACK; O_retired=1.
- OP_STORE with I_mem_ready delayed 3 cycles in MEMORY → 0,1,2,3,4,4,4,4,5; O_mem_we=1 throughout MEMORY; O_regfile_we=0; O_pc_op=1.
- OP_JMP with I_branch_taken=1 in EXECUTE → O_pc_op=2 in WRITEBACK, no regfile write; repeat with 0 → O_pc_op=1.
- I_mem_ready held 0 in FETCH → O_state=7 and O_fault=1 after 16 cycles; stays there until I_reset=0, then O_state=0, O_fault=0.
- I_halt_req=1 during WRITEBACK → HALT with all enables 0 for 10 cycles; I_resume=1 → FETCH next cycle; O_retired increments exactly once.
- Assert I_reset=0 asynchronously mid-MEMORY → outputs clear immediately without waiting for a clock edge; O_retired=0; 65536 retired instructions (preload by forcing) → O_retired wraps to 0.
